// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the fifo_sync write arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAX_REQ = 8;
  localparam int STAT_W  = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, with wrap.
module rr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr < NUM_REQ and k < NUM_REQ, so a single subtraction performs the wrap
      sum = {1'b0, pointer} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      pos = sum[IDX_W-1:0];
      if (en && !found && req[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one fifo_sync write port among NUM_REQ producers.
// Optional accept counters and stat_sel/stat_cnt ports with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 72,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_afull,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          ovf_err
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]              stat_sel,
  output logic [STAT_W-1:0]             stat_cnt
`endif
);

  state_e                 state_q, state_d;
  logic                   permit;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   xfer;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   wr_en_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [IDX_W-1:0]       grant_idx_q;
  logic                   ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (fifo_ready)  state_d = RUN;
      RUN:     if (!fifo_ready) state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // afull is the real throttle; it leaves room for the write already registered
  always_comb begin
    permit = (state_q == RUN) && fifo_ready && !fifo_full && !fifo_afull;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req       (req_valid),
    .pointer   (ptr_q),
    .en        (permit),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign ptr_d     = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_en_q <= xfer;
      ovf_q   <= ovf_q | (wr_en_q & fifo_full);
      if (xfer) begin
        wr_data_q   <= win_data;
        grant_idx_q <= gnt_idx;
        ptr_q       <= ptr_d;
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant_idx    = grant_idx_q;
  assign ovf_err      = ovf_q;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] stat_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      stat_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + STAT_W'(1);
      stat_cnt_q <= cnt_q[stat_sel];
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=72).
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 72;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           fifo_ready;
  logic           fifo_full;
  logic           fifo_afull;
  logic           fifo_wr_en;
  logic [DW-1:0]  fifo_wr_data;
  logic [IW-1:0]  grant_idx;
  logic           ovf_err;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [IW-1:0]  stat_sel;
  logic [15:0]    stat_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] dv [NR];

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_ready   (fifo_ready),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_idx    (grant_idx),
    .ovf_err      (ovf_err)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_sel     (stat_sel),
    .stat_cnt     (stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // one cycle where producer exp_idx must be granted and written one edge later
  task automatic grant_step(input string tag, input logic [NR-1:0] exp_rdy, input int exp_idx);
    #1;
    chk({tag, "_rdy"}, DW'(req_ready), DW'(exp_rdy));
    cyc();
    chk({tag, "_wr_en"}, DW'(fifo_wr_en), DW'(1));
    chk({tag, "_idx"}, DW'(grant_idx), DW'(exp_idx));
    chk({tag, "_data"}, fifo_wr_data, dv[exp_idx]);
  endtask

  task automatic idle_step(input string tag);
    #1;
    chk({tag, "_rdy"}, DW'(req_ready), '0);
    cyc();
    chk({tag, "_wr_en"}, DW'(fifo_wr_en), '0);
  endtask

  initial begin
    dv[0] = 72'h11_1111_1111_1111_1111;
    dv[1] = 72'h22_2222_2222_2222_2222;
    dv[2] = 72'h33_3333_3333_3333_3333;
    dv[3] = 72'h44_4444_4444_4444_4444;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dv[i];
    rst        = 1'b0;
    req_valid  = '0;
    fifo_ready = 1'b0;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel   = '0;
`endif

    repeat (2) cyc();
    chk("rst_rdy", DW'(req_ready), '0);
    chk("rst_wr_en", DW'(fifo_wr_en), '0);
    chk("rst_data", fifo_wr_data, '0);
    chk("rst_idx", DW'(grant_idx), '0);
    chk("rst_ovf", DW'(ovf_err), '0);

    rst       = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) idle_step("not_ready");

    fifo_ready = 1'b1;
    idle_step("wait_to_run");

    for (int t = 0; t < 8; t++) grant_step("rr_all", NR'(1 << (t % NR)), t % NR);

    req_valid = 4'b0011;
    grant_step("ptr_set0", 4'b0001, 0);
    grant_step("ptr_set1", 4'b0010, 1);
    req_valid = 4'b1010;
    grant_step("sparse_a", 4'b1000, 3);
    grant_step("sparse_b", 4'b0010, 1);
    grant_step("sparse_c", 4'b1000, 3);

    req_valid = 4'b1111;
    grant_step("pre_afull0", 4'b0001, 0);
    grant_step("pre_afull1", 4'b0010, 1);
    fifo_afull = 1'b1;
    for (int i = 0; i < 5; i++) idle_step("afull");
    fifo_afull = 1'b0;
    grant_step("post_afull2", 4'b0100, 2);
    grant_step("post_afull3", 4'b1000, 3);
    chk("afull_ovf", DW'(ovf_err), '0);

    req_valid = 4'b0001;
    grant_step("ovf_wr", 4'b0001, 0);
    fifo_full = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("full_rdy", DW'(req_ready), '0);
    chk("ovf_before", DW'(ovf_err), '0);
    cyc();
    chk("ovf_set", DW'(ovf_err), DW'(1));
    chk("ovf_wr_en", DW'(fifo_wr_en), '0);
    fifo_full = 1'b0;
    req_valid = 4'b1111;
    grant_step("ovf_cont", 4'b0010, 1);
    chk("ovf_sticky", DW'(ovf_err), DW'(1));

    grant_step("pre_rst", 4'b0100, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_en", DW'(fifo_wr_en), '0);
    chk("mid_rst_idx", DW'(grant_idx), '0);
    chk("mid_rst_data", fifo_wr_data, '0);
    chk("mid_rst_ovf", DW'(ovf_err), '0);
    chk("mid_rst_rdy", DW'(req_ready), '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stat_rst", DW'(stat_cnt), '0);
`endif
    idle_step("rst_wait");
    grant_step("restart", 4'b0001, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin write arbiter that shares the single write port of one fifo_sync instance among NUM_REQ independent producers.
- Each producer presents a valid/ready stream. The arbiter grants at most one producer per cycle and registers the winning word onto fifo_sync wr_en/wr_data.
- It never writes while fifo_sync is not ready (post-reset settling) or nearly full.
- Sits directly in front of fifo_sync in the same clock domain.

Parameters:
- NUM_REQ, 4, number of producers; legal range 2..8.
- DATA_WIDTH, 72, word width; must equal fifo_sync FIFO_WIDTH.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  producer i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- fifo_ready  in  1  fifo_sync ready.
- fifo_full  in  1  fifo_sync full.
- fifo_afull  in  1  fifo_sync almost-full, programmed offset >= 2.
- fifo_wr_en  out  1  registered write enable to fifo_sync.
- fifo_wr_data  out  DATA_WIDTH  registered write data.
- grant_idx  out  IDX_W  index of the last accepted producer.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async): fifo_wr_en=0, fifo_wr_data=0, req_ready=0, grant_idx=0, ovf_err=0, rr pointer=0, state=WAIT.
- State machine (2 states):
  - WAIT -> RUN on the first cycle fifo_ready=1.
  - RUN -> WAIT whenever fifo_ready=0.
  - In WAIT, req_ready=0.
- Permit condition: permit = (state==RUN) & fifo_ready & !fifo_full & !fifo_afull.
- Grant:
  - When permit=1, req_ready is a combinational one-hot of the first asserted req_valid, searching from rr pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - When no req_valid is asserted or permit=0, req_ready=0.
  - req_ready never asserts for a producer whose req_valid=0.
- Transfer: on a granted cycle, the next edge registers fifo_wr_data=req_data[i], fifo_wr_en=1, grant_idx=i, rr pointer=(i+1) mod NUM_REQ. The pointer wraps NUM_REQ-1 -> 0.
- Idle cycles: fifo_wr_en=0 on any edge with no transfer. fifo_wr_data holds its last value.
- Latency and throughput: one cycle from req_valid&req_ready to fifo_wr_en. Sustained rate is 1 word/cycle.
- Fairness: with all producers continuously valid, grants cycle 0,1,..,NUM_REQ-1,0. No producer waits more than NUM_REQ-1 grants.
- Producer rule: req_valid and req_data must hold stable until accepted. The arbiter never drops or duplicates an accepted word.
- Flow-control margin: fifo_afull is the primary throttle, which absorbs the one in-flight registered write. fifo_full also blocks grants.
- Overflow: ovf_err sets when fifo_wr_en=1 and fifo_full=1 in the same cycle. It clears only on reset.
- fifo_ready falls mid-stream: grants stop the same cycle. A write already registered still issues on the next edge.
- Reset mid-operation: all state clears immediately. Producers must re-present unaccepted words.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined:
  - Adds per-producer 16-bit saturating accept counters, stopping at 16'hFFFF.
  - Adds ports stat_sel in IDX_W and stat_cnt out 16. stat_cnt is the registered count of producer stat_sel, with 1-cycle read latency.
  - Counters clear on reset.
- Undefined: no counters and no stat ports; the core is otherwise identical.

Decomposition:
- Package fifo_wr_arb_pkg:
  - state enum {WAIT, RUN};
  - MAX_REQ=8;
  - STAT_W=16.
- Sub-module rr_arbiter (combinational): inputs req, pointer, en; output one-hot grant and its index. Instantiated once.

Test Plan:
- Reset then fifo_ready held 0 for 10 cycles with req_valid=4'b1111 -> req_ready=0 and fifo_wr_en=0 throughout; after fifo_ready=1, first grant goes to producer 0.
- All four producers continuously valid with distinct data, 8 transfers -> grant_idx sequence 0,1,2,3,0,1,2,3; each fifo_wr_en pulse carries the granted word one cycle after acceptance.
- req_valid=4'b1010, pointer=2 -> grant order 3,1,3; requesters 0 and 2 never see req_ready.
- fifo_afull asserted for 5 cycles during a full-rate stream -> zero grants in those cycles, no lost words, ovf_err stays 0.
- Force fifo_full=1 coincident with a registered write -> ovf_err=1 and it stays 1 until rst.
- rst pulsed low mid-stream -> outputs reset asynchronously; after release and fifo_ready=1, arbitration restarts at producer 0. With FIFO_WR_ARB_STATS_EN, stat_cnt reads 0.
